down_counter_4: RTL

Loadable 4-bit down-counter with start/busy/done handshake. It is the decrement-side counterpart of the processor's incrementing program-counter path. The control unit uses it to sequence multi-cycle operations such as shift counts, iterative multiply/divide steps, and wait states. Each decrement is performed by a structural ripple-borrow decrementor, and the result is registered under a small FSM.

---
 rtl/down_counter_4_pkg.sv | 15 +
 rtl/down_counter_4_if.sv | 24 ++
 rtl/down_counter_4_decrementor.sv | 22 ++
 rtl/down_counter_4.sv | 81 ++++++++
 4 files changed

// File: rtl/down_counter_4_pkg.sv
// Shared constants and FSM encodings for the loadable down-counter.
package down_counter_4_pkg;

    localparam int unsigned WIDTH = 4;

    typedef logic [WIDTH-1:0] count_t;

    // 2'b11 is unused and treated as IDLE by the FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/down_counter_4_if.sv
// Control/status bundle between the sequencing control unit and the down-counter.
interface down_counter_4_if;
    import down_counter_4_pkg::*;

    logic   load;
    count_t din;
    logic   start;
    logic   hold;
    count_t cnt;
    logic   zero;
    logic   busy;
    logic   done;

    modport master (
        output load, din, start, hold,
        input  cnt, zero, busy, done
    );

    modport slave (
        input  load, din, start, hold,
        output cnt, zero, busy, done
    );

endinterface

// File: rtl/down_counter_4_decrementor.sv
// Ripple-borrow decrementor: a chain of half-subtractor stages with borrow-in fixed at 1.
module down_counter_4_decrementor
    import down_counter_4_pkg::*;
(
    input  count_t operand,
    output count_t result,
    output logic   bout
);

    logic [WIDTH:0] borrow;

    assign borrow[0] = 1'b1;

    // Half-subtractor per bit: difference = a ^ b, borrow = ~a & b.
    for (genvar i = 0; i < WIDTH; i++) begin : g_hsub
        assign result[i]   = operand[i] ^ borrow[i];
        assign borrow[i+1] = ~operand[i] & borrow[i];
    end

    assign bout = borrow[WIDTH];

endmodule

// File: rtl/down_counter_4.sv
// Loadable down-counter with start/busy/done handshake for multi-cycle sequencing.
module down_counter_4
    import down_counter_4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    down_counter_4_if.slave  bus
);

    state_t state;
    count_t cnt;
    logic   busy;
    logic   done;

    count_t dec;
    logic   bout;
    count_t eff_cnt;

    down_counter_4_decrementor u_dec (
        .operand (cnt),
        .result  (dec),
        .bout    (bout)
    );

    // Count a START will use: a same-cycle LOAD takes precedence over the held value.
    assign eff_cnt = bus.load ? bus.din : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_COUNT: begin
                    if (!bus.hold) begin
                        // bout guards against ever wrapping from zero.
                        if (!bout) begin
                            cnt <= dec;
                        end
                        if (bout || dec == '0) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (bus.load) begin
                        cnt <= bus.din;
                    end
                    if (bus.start) begin
                        cnt <= eff_cnt;
                        if (eff_cnt != '0) begin
                            state <= ST_COUNT;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.cnt  = cnt;
    assign bus.zero = (cnt == '0);
    assign bus.busy = busy;
    assign bus.done = done;

endmodule
